// File: rtl/io_intr_ctrl.sv
// Small interrupt controller with a simple I/O port: synchronised edge-triggered
// IRQ lines, maskable lowest-index arbitration, and a REQ/SERVICE handshake.
module io_intr_ctrl #(
    parameter int W     = 16,
    parameter int N_IRQ = 4,
    parameter int VEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic [W-1:0]     in_port,
    input  logic             out_we,
    input  logic [W-1:0]     out_wdata,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             interrupt,
    output logic [VEC_W-1:0] int_vector,
    output logic [N_IRQ-1:0] pending,
    output logic             busy,
    output logic [W-1:0]     in_data,
    output logic [W-1:0]     out_port
);

    if ((N_IRQ < 1) || (N_IRQ > 16) || ((1 << VEC_W) < N_IRQ)) begin : g_cfg_check
        $error("io_intr_ctrl: need 1 <= N_IRQ <= 16 and 2**VEC_W >= N_IRQ");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [N_IRQ-1:0] irq_s1;
    logic [N_IRQ-1:0] irq_s2;
    logic [N_IRQ-1:0] irq_prev;
    logic [2:0]       hist_ok;
    logic [N_IRQ-1:0] irq_rise;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] req_vec;
    logic [N_IRQ-1:0] ack_clr;
    logic             arb_hit;
    logic [VEC_W-1:0] arb_idx;
    logic             vec_load;
    logic [W-1:0]     in_s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_s1   <= '0;
            irq_s2   <= '0;
            irq_prev <= '0;
            hist_ok  <= '0;
        end else begin
            irq_s1   <= irq_in;
            irq_s2   <= irq_s1;
            irq_prev <= irq_s2;
            hist_ok  <= {hist_ok[1:0], 1'b1};
        end
    end

    // Edges count only once irq_prev holds a real post-reset sample, so a line
    // held high through reset is not mistaken for a fresh rising edge.
    assign irq_rise = irq_s2 & ~irq_prev & {N_IRQ{hist_ok[2]}};
    assign req_vec  = pending & mask;

    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (req_vec[i-1]) begin
                arb_hit = 1'b1;
                arb_idx = VEC_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        vec_load = 1'b0;
        ack_clr  = '0;
        case (state)
            IDLE: begin
                if (arb_hit) begin
                    state_n  = REQ;
                    vec_load = 1'b1;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_n = SERVICE;
                    ack_clr = N_IRQ'(1) << int_vector;
                end
            end
            SERVICE: begin
                if (int_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign interrupt = (state == REQ);
    assign busy      = (state != IDLE);

    // A new edge on the channel being acknowledged re-sets its pending bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            int_vector <= '0;
            mask       <= '1;
        end else begin
            pending <= (pending & ~ack_clr) | irq_rise;
            if (vec_load) begin
                int_vector <= arb_idx;
            end
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_s1    <= '0;
            in_data  <= '0;
            out_port <= '0;
        end else begin
            in_s1   <= in_port;
            in_data <= in_s1;
            if (out_we) begin
                out_port <= out_wdata;
            end
        end
    end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Scoreboard bench for io_intr_ctrl: expectations queued at stimulus time,
// popped when the controller raises its request or produces data.
module tb_io_intr_ctrl;

    localparam int W     = 16;
    localparam int N_IRQ = 4;
    localparam int VEC_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic [W-1:0]     in_port;
    logic             out_we;
    logic [W-1:0]     out_wdata;
    logic             int_ack;
    logic             int_done;
    logic             interrupt;
    logic [VEC_W-1:0] int_vector;
    logic [N_IRQ-1:0] pending;
    logic             busy;
    logic [W-1:0]     in_data;
    logic [W-1:0]     out_port;

    io_intr_ctrl #(.W(W), .N_IRQ(N_IRQ), .VEC_W(VEC_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .in_port    (in_port),
        .out_we     (out_we),
        .out_wdata  (out_wdata),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .interrupt  (interrupt),
        .int_vector (int_vector),
        .pending    (pending),
        .busy       (busy),
        .in_data    (in_data),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        val_q.push_back(val);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] v;
        if (tag_q.size() == 0) begin
            check("sb_underflow", 32'(tag_q.size()), 32'd1);
        end else begin
            t = tag_q.pop_front();
            v = val_q.pop_front();
            check(t, obs, v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(output int cyc);
        cyc = 99;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (interrupt === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    task automatic write_mask(input logic [N_IRQ-1:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    task automatic lines_low();
        irq_in = '0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst        = 1'b1;
        irq_in     = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        in_port    = 16'hA5A5;
        out_we     = 1'b0;
        out_wdata  = '0;
        int_ack    = 1'b0;
        int_done   = 1'b0;
        repeat (3) tick();
        check("rst_interrupt", 32'(interrupt), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_vector",    32'(int_vector), 32'd0);
        check("rst_pending",   32'(pending), 32'd0);
        check("rst_out_port",  32'(out_port), 32'd0);
        check("rst_in_data",   32'(in_data), 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        // Single channel: latency, handshake, ignored strobes
        sb_push("ch2_latency", 32'd4);
        sb_push("ch2_vector",  32'd2);
        irq_in = 4'b0100;
        wait_irq(cyc);
        sb_pop(32'(cyc));
        sb_pop(32'(int_vector));
        check("ch2_pending", 32'(pending), 32'h4);
        do_done();
        check("done_in_req_ignored", 32'(interrupt), 32'd1);
        do_ack();
        check("ack_pending",   32'(pending), 32'd0);
        check("ack_interrupt", 32'(interrupt), 32'd0);
        check("ack_busy",      32'(busy), 32'd1);
        check("svc_vector",    32'(int_vector), 32'd2);
        do_ack();
        check("ack_in_svc_ignored", 32'(busy), 32'd1);
        do_done();
        check("done_busy", 32'(busy), 32'd0);

        // Two simultaneous requests: lowest index first
        lines_low();
        sb_push("pair_first",  32'd1);
        sb_push("pair_rearb",  32'd1);
        sb_push("pair_second", 32'd3);
        irq_in = 4'b1010;
        wait_irq(cyc);
        sb_pop(32'(int_vector));
        check("pair_pending", 32'(pending), 32'hA);
        do_ack();
        check("pair_pending_after_ack", 32'(pending), 32'h8);
        do_done();
        check("pair_idle", 32'(busy), 32'd0);
        wait_irq(cyc);
        sb_pop(32'(cyc));
        sb_pop(32'(int_vector));
        do_ack();
        do_done();

        // Masked channel stays pending until unmasked
        lines_low();
        write_mask(4'b1101);
        irq_in = 4'b0010;
        repeat (6) tick();
        check("masked_pending",   32'(pending), 32'h2);
        check("masked_interrupt", 32'(interrupt), 32'd0);
        sb_push("unmask_latency", 32'd1);
        sb_push("unmask_vector",  32'd1);
        write_mask(4'b1111);
        check("unmask_not_yet", 32'(interrupt), 32'd0);
        wait_irq(cyc);
        sb_pop(32'(cyc));
        sb_pop(32'(int_vector));
        do_ack();
        do_done();

        // New edge landing on the same edge as the acknowledge
        lines_low();
        sb_push("race_first_vector",  32'd0);
        sb_push("race_rereq_latency", 32'd1);
        sb_push("race_rereq_vector",  32'd0);
        irq_in = 4'b0001;
        wait_irq(cyc);
        sb_pop(32'(int_vector));
        irq_in = 4'b0000;
        repeat (3) tick();
        irq_in = 4'b0001;
        tick();
        tick();
        do_ack();
        check("race_pending",   32'(pending), 32'h1);
        check("race_busy",      32'(busy), 32'd1);
        check("race_interrupt", 32'(interrupt), 32'd0);
        do_done();
        wait_irq(cyc);
        sb_pop(32'(cyc));
        sb_pop(32'(int_vector));
        do_ack();
        check("race_cleared", 32'(pending), 32'd0);
        do_done();

        // Reset during SERVICE with other channels pending; lines held high
        lines_low();
        write_mask(4'b0001);
        sb_push("svc_rst_vector", 32'd0);
        irq_in = 4'b1011;
        wait_irq(cyc);
        sb_pop(32'(int_vector));
        do_ack();
        check("svc_pending", 32'(pending), 32'hA);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("svc_rst_pending",   32'(pending), 32'd0);
        check("svc_rst_busy",      32'(busy), 32'd0);
        check("svc_rst_interrupt", 32'(interrupt), 32'd0);
        check("svc_rst_vector",    32'(int_vector), 32'd0);
        repeat (8) tick();
        check("held_line_pending",   32'(pending), 32'd0);
        check("held_line_interrupt", 32'(interrupt), 32'd0);
        lines_low();
        sb_push("post_rst_latency", 32'd4);
        sb_push("post_rst_vector",  32'd3);
        irq_in = 4'b1000;
        wait_irq(cyc);
        sb_pop(32'(cyc));
        sb_pop(32'(int_vector));
        do_ack();
        do_done();

        // I/O port paths
        sb_push("out_load", 32'hBEEF);
        out_we    = 1'b1;
        out_wdata = 16'hBEEF;
        tick();
        out_we    = 1'b0;
        out_wdata = 16'h0000;
        sb_pop(32'(out_port));
        tick();
        check("out_hold", 32'(out_port), 32'hBEEF);
        sb_push("in_lat1", 32'hA5A5);
        sb_push("in_lat2", 32'h1234);
        in_port = 16'h1234;
        tick();
        sb_pop(32'(in_data));
        tick();
        sb_pop(32'(in_data));

        check("sb_drain", 32'(tag_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
